// File: rtl/pyramid_level_scheduler.sv
// Walks the HOG image pyramid one level at a time, shrinking dims by (SCALE-1)/SCALE per level.
// state | meaning: IDLE accept frame | START pulse level | WAIT level running | CALC shrink dims | DONE frame end
module pyramid_level_scheduler #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int SCALE        = 9,
    parameter int LEVELS       = 15,
    parameter int MIN_WIDTH    = 64,
    parameter int MIN_HEIGHT   = 128,
    parameter int DIM_WIDTH    = 11,
    parameter int LVL_WIDTH    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_frame_start,
    output logic                 o_frame_ready,
    output logic                 o_busy,
    input  logic                 i_abort,
    output logic                 o_level_start,
    output logic [LVL_WIDTH-1:0] o_level_index,
    output logic [DIM_WIDTH-1:0] o_level_width,
    output logic [DIM_WIDTH-1:0] o_level_height,
    input  logic                 i_level_done,
    output logic                 o_frame_done,
    output logic [LVL_WIDTH-1:0] o_levels_processed
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CALC, S_DONE} state_t;

    localparam int                   PROD_W   = DIM_WIDTH + 16;
    localparam logic [15:0]          RATIO_Q  = 16'((65536 * (SCALE - 1)) / SCALE);
    localparam logic [DIM_WIDTH-1:0] IMG_W    = DIM_WIDTH'(IMAGE_WIDTH);
    localparam logic [DIM_WIDTH-1:0] IMG_H    = DIM_WIDTH'(IMAGE_HEIGHT);
    localparam logic [DIM_WIDTH-1:0] MIN_W    = DIM_WIDTH'(MIN_WIDTH);
    localparam logic [DIM_WIDTH-1:0] MIN_H    = DIM_WIDTH'(MIN_HEIGHT);
    localparam logic [LVL_WIDTH-1:0] LAST_IDX = LVL_WIDTH'(LEVELS - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [LVL_WIDTH-1:0] r_level_index;
    logic [DIM_WIDTH-1:0] r_level_width;
    logic [DIM_WIDTH-1:0] r_level_height;
    logic [LVL_WIDTH-1:0] r_levels_processed;

    logic [PROD_W-1:0]    w_width_prod;
    logic [PROD_W-1:0]    w_height_prod;
    logic [DIM_WIDTH-1:0] w_next_width;
    logic [DIM_WIDTH-1:0] w_next_height;
    logic                 w_img_too_small;
    logic                 w_next_too_small;
    logic                 w_last_level;

    // Truncating Q16 multiply; the shifted-down product is the normative next dimension.
    assign w_width_prod     = PROD_W'(r_level_width) * PROD_W'(RATIO_Q);
    assign w_height_prod    = PROD_W'(r_level_height) * PROD_W'(RATIO_Q);
    assign w_next_width     = DIM_WIDTH'(w_width_prod >> 16);
    assign w_next_height    = DIM_WIDTH'(w_height_prod >> 16);
    assign w_img_too_small  = (IMG_W < MIN_W) || (IMG_H < MIN_H);
    assign w_next_too_small = (w_next_width < MIN_W) || (w_next_height < MIN_H);
    assign w_last_level     = (r_level_index == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_frame_start) w_next_state = w_img_too_small ? S_DONE : S_START;
                S_START: w_next_state = S_WAIT;
                S_WAIT:  if (i_level_done) w_next_state = w_last_level ? S_DONE : S_CALC;
                S_CALC:  w_next_state = w_next_too_small ? S_DONE : S_START;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Level registers: abort only suppresses the done-count increment, partial counts are kept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level_index      <= '0;
            r_level_width      <= IMG_W;
            r_level_height     <= IMG_H;
            r_levels_processed <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_level_index      <= '0;
                        r_level_width      <= IMG_W;
                        r_level_height     <= IMG_H;
                        r_levels_processed <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_level_done && !i_abort) begin
                        r_levels_processed <= r_levels_processed + 1'b1;
                    end
                end
                S_CALC: begin
                    r_level_index  <= r_level_index + 1'b1;
                    r_level_width  <= w_next_width;
                    r_level_height <= w_next_height;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_frame_ready      = (r_state == S_IDLE);
        o_busy             = (r_state != S_IDLE);
        o_level_start      = (r_state == S_START);
        o_frame_done       = (r_state == S_DONE);
        o_level_index      = r_level_index;
        o_level_width      = r_level_width;
        o_level_height     = r_level_height;
        o_levels_processed = r_levels_processed;
    end

endmodule

// File: tb/tb_pyramid_level_scheduler.sv
// Scoreboard bench: three scheduler instances (default, LEVELS=3, IMAGE_HEIGHT=100) exercised in turn.
module tb_pyramid_level_scheduler;

    typedef struct {
        int inst;
        int idx;
        int w;
        int h;
    } lvl_rec_t;

    typedef struct {
        int inst;
        int lp;
    } done_rec_t;

    localparam int RATIO_Q = (65536 * 8) / 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs [3];
    logic       ab [3];
    logic       ld [3];
    logic       fr [3];
    logic       by [3];
    logic       ls [3];
    logic       fd [3];
    logic [3:0] li [3];
    logic [3:0] lp [3];
    logic [10:0] lw [3];
    logic [10:0] lh [3];

    int n_checks = 0;
    int n_errors = 0;

    lvl_rec_t  q_lvl[$];
    done_rec_t q_done[$];
    int        obs_h[$];
    int        obs_w[$];

    always #5 clk = ~clk;

    pyramid_level_scheduler u_dut (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs[0]), .o_frame_ready(fr[0]), .o_busy(by[0]),
        .i_abort(ab[0]), .o_level_start(ls[0]), .o_level_index(li[0]), .o_level_width(lw[0]),
        .o_level_height(lh[0]), .i_level_done(ld[0]), .o_frame_done(fd[0]), .o_levels_processed(lp[0])
    );

    pyramid_level_scheduler #(.LEVELS(3)) u_dut_lv3 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs[1]), .o_frame_ready(fr[1]), .o_busy(by[1]),
        .i_abort(ab[1]), .o_level_start(ls[1]), .o_level_index(li[1]), .o_level_width(lw[1]),
        .o_level_height(lh[1]), .i_level_done(ld[1]), .o_frame_done(fd[1]), .o_levels_processed(lp[1])
    );

    pyramid_level_scheduler #(.IMAGE_HEIGHT(100)) u_dut_small (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs[2]), .o_frame_ready(fr[2]), .o_busy(by[2]),
        .i_abort(ab[2]), .o_level_start(ls[2]), .o_level_index(li[2]), .o_level_width(lw[2]),
        .o_level_height(lh[2]), .i_level_done(ld[2]), .o_frame_done(fd[2]), .o_levels_processed(lp[2])
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int next_dim(input int d);
        longint p;
        p = longint'(d) * longint'(RATIO_Q);
        return int'(p >> 16);
    endfunction

    // Monitor: every level_start / frame_done must match the front of its queue.
    always @(negedge clk) begin : mon
        lvl_rec_t  e;
        done_rec_t d;
        for (int k = 0; k < 3; k++) begin
            if (ls[k] === 1'b1) begin
                if (k == 0) begin
                    obs_h.push_back(int'(lh[0]));
                    obs_w.push_back(int'(lw[0]));
                end
                if (q_lvl.size() == 0) begin
                    check_val("spurious_level_start", ls[k], 0);
                end else begin
                    e = q_lvl.pop_front();
                    check_val("lvl_inst", k, e.inst);
                    check_val("lvl_index", li[k], e.idx);
                    check_val("lvl_width", lw[k], e.w);
                    check_val("lvl_height", lh[k], e.h);
                end
            end
            if (fd[k] === 1'b1) begin
                if (q_done.size() == 0) begin
                    check_val("spurious_frame_done", fd[k], 0);
                end else begin
                    d = q_done.pop_front();
                    check_val("done_inst", k, d.inst);
                    check_val("done_levels_processed", lp[k], d.lp);
                end
            end
        end
    end

    task automatic push_level(input int inst, input int idx, input int w, input int h);
        lvl_rec_t e;
        e.inst = inst;
        e.idx  = idx;
        e.w    = w;
        e.h    = h;
        q_lvl.push_back(e);
    endtask

    task automatic pulse_done(input int inst);
        repeat (5) tick();
        ld[inst] = 1'b1;
        tick();
        ld[inst] = 1'b0;
    endtask

    task automatic run_frame(input int inst, input int lv, input int img_w, input int img_h);
        int        cw;
        int        ch;
        int        n;
        bit        by_lv;
        done_rec_t d;
        cw    = img_w;
        ch    = img_h;
        n     = 0;
        by_lv = 1'b0;
        while (cw >= 64 && ch >= 128) begin
            push_level(inst, n, cw, ch);
            n++;
            if (n == lv) begin
                by_lv = 1'b1;
                break;
            end
            cw = next_dim(cw);
            ch = next_dim(ch);
        end
        d.inst = inst;
        d.lp   = n;
        q_done.push_back(d);

        check_val("accept_ready", fr[inst], 1);
        fs[inst] = 1'b1;
        tick();
        fs[inst] = 1'b0;
        if (n == 0) begin
            check_val("small_done_T1", fd[inst], 1);
            check_val("small_no_start", ls[inst], 0);
        end else begin
            for (int k = 0; k < n; k++) begin
                check_val("level_start_latency", ls[inst], 1);
                pulse_done(inst);
                if (k == n - 1 && by_lv) begin
                    check_val("done_after_last_level", fd[inst], 1);
                end else begin
                    check_val("calc_no_start", ls[inst], 0);
                    check_val("calc_no_done", fd[inst], 0);
                    tick();
                    if (k == n - 1) check_val("done_after_early_stop", fd[inst], 1);
                end
            end
        end
        check_val("final_levels_processed", lp[inst], n);
        tick();
        check_val("ready_after_done", fr[inst], 1);
        check_val("done_one_cycle", fd[inst], 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int exp_h[11];
        exp_h = '{480, 426, 378, 335, 297, 263, 233, 207, 183, 162, 143};
        for (int k = 0; k < 3; k++) begin
            fs[k] = 1'b0;
            ab[k] = 1'b0;
            ld[k] = 1'b0;
        end

        // Reset and reset values
        rst = 1'b1;
        repeat (3) tick();
        check_val("rst_frame_ready", fr[0], 1);
        check_val("rst_busy", by[0], 0);
        check_val("rst_level_start", ls[0], 0);
        check_val("rst_frame_done", fd[0], 0);
        check_val("rst_level_index", li[0], 0);
        check_val("rst_level_width", lw[0], 640);
        check_val("rst_level_height", lh[0], 480);
        check_val("rst_levels_processed", lp[0], 0);
        rst = 1'b0;
        tick();

        // Full default frame, early stop at height 127
        obs_h.delete();
        obs_w.delete();
        run_frame(0, 15, 640, 480);
        check_val("full_level_count", obs_h.size(), 11);
        for (int k = 0; k < 11 && k < obs_h.size(); k++) check_val("full_height", obs_h[k], exp_h[k]);
        if (obs_w.size() >= 3) begin
            check_val("full_width0", obs_w[0], 640);
            check_val("full_width1", obs_w[1], 568);
            check_val("full_width2", obs_w[2], 504);
        end

        // LEVELS=3 and too-small image instances; back-to-back on the LEVELS=3 one
        run_frame(1, 3, 640, 480);
        run_frame(1, 3, 640, 480);
        run_frame(2, 15, 640, 100);

        // Ignore rules in IDLE
        ld[0] = 1'b1;
        ab[0] = 1'b1;
        tick();
        ld[0] = 1'b0;
        ab[0] = 1'b0;
        check_val("idle_ignore_ready", fr[0], 1);
        check_val("idle_ignore_lp", lp[0], 11);

        // Abort in WAIT at level index 2, frame_start in WAIT ignored
        push_level(0, 0, 640, 480);
        push_level(0, 1, 568, 426);
        push_level(0, 2, 504, 378);
        fs[0] = 1'b1;
        tick();
        fs[0] = 1'b0;
        pulse_done(0);
        tick();
        pulse_done(0);
        tick();
        check_val("abort_setup_index", li[0], 2);
        tick();
        fs[0] = 1'b1;
        tick();
        fs[0] = 1'b0;
        check_val("wait_ignore_fs_busy", by[0], 1);
        check_val("wait_ignore_fs_start", ls[0], 0);
        check_val("wait_ignore_fs_index", li[0], 2);
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        check_val("abort_ready", fr[0], 1);
        check_val("abort_no_done", fd[0], 0);
        check_val("abort_partial_lp", lp[0], 2);
        check_val("abort_no_start", ls[0], 0);
        tick();
        check_val("abort_stays_idle", fr[0], 1);

        // level_done during START ignored, then abort+level_done together
        push_level(0, 0, 640, 480);
        fs[0] = 1'b1;
        tick();
        fs[0] = 1'b0;
        ld[0] = 1'b1;
        tick();
        ld[0] = 1'b0;
        check_val("start_ignore_ld_lp", lp[0], 0);
        check_val("start_ignore_ld_busy", by[0], 1);
        check_val("start_ignore_ld_nostart", ls[0], 0);
        ld[0] = 1'b1;
        ab[0] = 1'b1;
        tick();
        ld[0] = 1'b0;
        ab[0] = 1'b0;
        check_val("abort_wins_ready", fr[0], 1);
        check_val("abort_wins_lp", lp[0], 0);

        // Restart after abort begins at index 0, 640x480
        run_frame(0, 15, 640, 480);

        // Reset mid-frame
        push_level(0, 0, 640, 480);
        push_level(0, 1, 568, 426);
        fs[0] = 1'b1;
        tick();
        fs[0] = 1'b0;
        pulse_done(0);
        tick();
        check_val("midrst_setup_start", ls[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_ready", fr[0], 1);
        check_val("midrst_index", li[0], 0);
        check_val("midrst_width", lw[0], 640);
        check_val("midrst_height", lh[0], 480);
        check_val("midrst_lp", lp[0], 0);
        check_val("midrst_start", ls[0], 0);
        repeat (3) tick();

        check_val("level_queue_empty", q_lvl.size(), 0);
        check_val("done_queue_empty", q_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
